y86_instr_encoder: RTL and testbench
====================================

Name: y86_instr_encoder

Overview:
- Encoder counterpart to the Y86-64 fetch/decode path: accepts one decoded instruction (icode, ifun, rA, rB, valC) per handshake and serialises it into instruction memory, one byte per cycle, in the exact byte format fetch consumes.
- Used as the program loader ahead of the sequential core and as the stimulus source for fetch benches.
- Maintains its own write pointer and reports the next free address, which is the PC of the next instruction.

Parameters:
- MEM_BYTES, 1024, instruction memory size in bytes; legal byte addresses are 0..MEM_BYTES-1.
- ADDR_W, 64, width of the address and pointer.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high reset.
- addr_load  in  1  load the write pointer from addr_init; honoured only in IDLE.
- addr_init  in  ADDR_W  new write-pointer value.
- in_valid  in  1  instruction fields valid.
- in_ready  out  1  encoder can accept an instruction (high exactly in IDLE).
- icode  in  4  instruction code.
- ifun  in  4  function code.
- rA  in  4  register A specifier.
- rB  in  4  register B specifier.
- valC  in  64  constant word.
- wr_en  out  1  byte write request to instruction memory.
- wr_ready  in  1  memory accepts the byte this cycle.
- wr_addr  out  ADDR_W  byte address.
- wr_data  out  8  byte value.
- done  out  1  one-cycle pulse: instruction fully written.
- ins_err  out  1  one-cycle pulse: invalid icode, instruction dropped.
- addr_err  out  1  one-cycle pulse: instruction would overflow memory, instruction dropped.
- next_pc  out  ADDR_W  current write pointer.

Behaviour:
- Reset (synchronous, active-high): state is IDLE; wr_en, done, ins_err and addr_err are 0; wr_addr, wr_data and next_pc are 0; in_ready is 1.
- Instruction length L by icode:
  - 0 halt, 1 nop, 9 ret: L=1.
  - 2 rrmovq/cmovXX, 6 OPq, A pushq, B popq: L=2.
  - 7 jXX, 8 call: L=9.
  - 3 irmovq, 4 rmmovq, 5 mrmovq: L=10.
  - icode C..F: invalid.
- Byte order:
  - Byte 0 is {icode, ifun}.
  - For L=2 or L=10, byte 1 is {rA, rB}.
  - valC follows little-endian (LSB first) in the last 8 bytes when L is 9 or 10.
  - Fields are emitted as given; no register-field sanitising.
- States:
  - IDLE.
  - EMIT, with byte index idx 0..L-1 and latched fields, length and base address.
- IDLE:
  - If addr_load, the pointer is set to addr_init.
  - If in_valid is also high that cycle, the new pointer applies to that instruction.
  - On in_valid with a valid icode and ptr+L <= MEM_BYTES: latch the fields, idx=0, go to EMIT.
  - On in_valid with an invalid icode: ins_err=1 the next cycle, stay IDLE, pointer unchanged.
  - On in_valid with a valid icode and ptr+L > MEM_BYTES: addr_err=1 the next cycle, stay IDLE, pointer unchanged.
  - If the icode is invalid and the instruction would also overflow, only ins_err fires.
  - The overflow check uses full ADDR_W+1-bit arithmetic; there is no wrap-around.
- EMIT:
  - wr_en=1, wr_addr=base+idx, wr_data=byte[idx].
  - While wr_ready=0, wr_en, wr_addr and wr_data hold stable.
  - On wr_ready=1: idx increments. If idx was L-1, go to IDLE, set next_pc=base+L, and pulse done=1 in the first IDLE cycle.
  - addr_load and in_valid are ignored in EMIT (in_ready=0).
- Timing:
  - Accept edge N: first byte presented in cycle N+1.
  - With wr_ready held high, an L-byte instruction occupies L+1 cycles from accept to the next accept.
- next_pc changes only on addr_load, on completion, or on reset.
- Reset mid-EMIT: immediate return to the reset state. Bytes already written are not retracted; the pointer returns to 0.

Test Plan:
- Reset, then nop at pointer 0 with wr_ready=1 -> one write (addr 0, data 0x10); done the following cycle; next_pc=1.
- addr_load 0x10 together with irmovq rA=F rB=3 valC=0x0123456789ABCDEF -> bytes 30 F3 EF CD AB 89 67 45 23 01 at addresses 0x10..0x19 on 10 consecutive cycles; next_pc=0x1A.
- call valC=0x40 with wr_ready low for 3 cycles on byte 2 -> wr_addr and wr_data stable during the stall; full sequence 80 40 00 00 00 00 00 00 00; done only after the 9th accepted byte.
- icode=0xC -> no wr_en; ins_err pulse; next_pc unchanged; the next valid instruction is written at the old pointer.
- MEM_BYTES=1024, pointer 1020, rmmovq (L=10) -> addr_err, no writes. Then ret -> byte 0x90 at addr 1020, next_pc=1021.
- Reset asserted at byte 4 of an irmovq -> the next cycle has wr_en=0, in_ready=1, next_pc=0; a following nop is written at address 0.

Source files
------------

// File: rtl/y86_instr_encoder.sv
// y86_instr_encoder
//
// Program loader for the Y86-64 core. It accepts one decoded instruction
// (icode, ifun, rA, rB, valC) per in_valid/in_ready handshake and writes it to
// instruction memory one byte per cycle, in the byte layout that fetch expects:
//   byte 0            {icode, ifun}
//   byte 1            {rA, rB}          (2- and 10-byte forms only)
//   last 8 bytes      valC, LSB first   (9- and 10-byte forms only)
// The encoder keeps its own write pointer. After a completed instruction the
// pointer (next_pc) is the PC of the next instruction.
//
// Ports
//   clk, reset          system clock, synchronous active-high reset
//   addr_load/addr_init load the write pointer (IDLE only)
//   in_valid/in_ready   instruction handshake; in_ready is high exactly in IDLE
//   icode/ifun/rA/rB/valC  decoded instruction fields
//   wr_en/wr_ready      byte write handshake toward instruction memory
//   wr_addr/wr_data     byte address and value
//   done                one-cycle pulse after the last byte is accepted
//   ins_err             one-cycle pulse: invalid icode, instruction dropped
//   addr_err            one-cycle pulse: instruction would not fit, dropped
//   next_pc             current write pointer
//
// States
//   state  | meaning
//   S_IDLE | waiting for an instruction; pointer may be loaded
//   S_EMIT | presenting byte idx of the latched instruction at base+idx

module y86_instr_encoder #(
  parameter int MEM_BYTES = 1024,
  parameter int ADDR_W    = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              addr_load,
  input  logic [ADDR_W-1:0] addr_init,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        icode,
  input  logic [3:0]        ifun,
  input  logic [3:0]        rA,
  input  logic [3:0]        rB,
  input  logic [63:0]       valC,
  output logic              wr_en,
  input  logic              wr_ready,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              done,
  output logic              ins_err,
  output logic              addr_err,
  output logic [ADDR_W-1:0] next_pc
);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_EMIT = 1'b1
  } state_t;

  // Memory size at the width of the overflow check, so that a pointer near the
  // top of the address space cannot wrap past the limit.
  localparam logic [ADDR_W:0] MEM_LIM = (ADDR_W + 1)'(MEM_BYTES);

  // Instruction length in bytes; 0 marks an invalid icode.
  function automatic logic [3:0] instr_len(input logic [3:0] code);
    logic [3:0] len;
    case (code)
      4'h0, 4'h1, 4'h9:        len = 4'd1;
      4'h2, 4'h6, 4'hA, 4'hB:  len = 4'd2;
      4'h7, 4'h8:              len = 4'd9;
      4'h3, 4'h4, 4'h5:        len = 4'd10;
      default:                 len = 4'd0;
    endcase
    return len;
  endfunction

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [3:0]        idx_q, idx_d;
  logic [3:0]        len_q, len_d;
  logic [3:0]        icode_q, icode_d;
  logic [3:0]        ifun_q, ifun_d;
  logic [3:0]        ra_q, ra_d;
  logic [3:0]        rb_q, rb_d;
  logic [63:0]       valc_q, valc_d;
  logic              done_q, done_d;
  logic              ins_err_q, ins_err_d;
  logic              addr_err_q, addr_err_d;

  // Acceptance checks in IDLE. A pointer load in the same cycle as in_valid
  // already applies to that instruction.
  logic [ADDR_W-1:0] eff_ptr;
  logic [3:0]        len_in;
  logic [ADDR_W:0]   end_sum;
  logic              fits;

  always_comb begin
    eff_ptr = addr_load ? addr_init : ptr_q;
    len_in  = instr_len(icode);
    end_sum = {1'b0, eff_ptr} + {{(ADDR_W - 3){1'b0}}, len_in};
    fits    = (end_sum <= MEM_LIM);
  end

  // Byte select for the current index. valc_first is the index of the first
  // valC byte (len-8); for 1- and 2-byte forms it wraps to a large value, so
  // index 1 of a 2-byte form always lands on the register byte.
  logic [3:0]  valc_first;
  logic [3:0]  valc_ofs;
  logic [63:0] valc_sh;
  logic [7:0]  cur_byte;

  always_comb begin
    valc_first = len_q - 4'd8;
    valc_ofs   = idx_q - valc_first;
    valc_sh    = valc_q >> {valc_ofs, 3'b000};
    if (idx_q == 4'd0) begin
      cur_byte = {icode_q, ifun_q};
    end else if (idx_q < valc_first) begin
      cur_byte = {ra_q, rb_q};
    end else begin
      cur_byte = valc_sh[7:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      ptr_q      <= '0;
      base_q     <= '0;
      idx_q      <= '0;
      len_q      <= '0;
      icode_q    <= '0;
      ifun_q     <= '0;
      ra_q       <= '0;
      rb_q       <= '0;
      valc_q     <= '0;
      done_q     <= 1'b0;
      ins_err_q  <= 1'b0;
      addr_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      base_q     <= base_d;
      idx_q      <= idx_d;
      len_q      <= len_d;
      icode_q    <= icode_d;
      ifun_q     <= ifun_d;
      ra_q       <= ra_d;
      rb_q       <= rb_d;
      valc_q     <= valc_d;
      done_q     <= done_d;
      ins_err_q  <= ins_err_d;
      addr_err_q <= addr_err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    base_d     = base_q;
    idx_d      = idx_q;
    len_d      = len_q;
    icode_d    = icode_q;
    ifun_d     = ifun_q;
    ra_d       = ra_q;
    rb_d       = rb_q;
    valc_d     = valc_q;
    done_d     = 1'b0;
    ins_err_d  = 1'b0;
    addr_err_d = 1'b0;
    in_ready   = 1'b0;
    wr_en      = 1'b0;
    wr_addr    = '0;
    wr_data    = '0;

    case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        if (addr_load) begin
          ptr_d = addr_init;
        end
        if (in_valid) begin
          // Invalid icode takes priority over the overflow check.
          if (len_in == 4'd0) begin
            ins_err_d = 1'b1;
          end else if (!fits) begin
            addr_err_d = 1'b1;
          end else begin
            icode_d = icode;
            ifun_d  = ifun;
            ra_d    = rA;
            rb_d    = rB;
            valc_d  = valC;
            len_d   = len_in;
            base_d  = eff_ptr;
            idx_d   = 4'd0;
            state_d = S_EMIT;
          end
        end
      end

      S_EMIT: begin
        wr_en   = 1'b1;
        wr_addr = base_q + {{(ADDR_W - 4){1'b0}}, idx_q};
        wr_data = cur_byte;
        if (wr_ready) begin
          if (idx_q == len_q - 4'd1) begin
            ptr_d   = base_q + {{(ADDR_W - 4){1'b0}}, len_q};
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign done     = done_q;
  assign ins_err  = ins_err_q;
  assign addr_err = addr_err_q;
  assign next_pc  = ptr_q;

endmodule

// File: tb/tb_y86_instr_encoder.sv
// Bench for y86_instr_encoder: expected memory writes are queued when an
// instruction is issued and compared as the encoder writes them.
module tb_y86_instr_encoder;

  localparam int MEM    = 1024;
  localparam int ADDR_W = 64;

  logic              clk = 1'b0;
  logic              reset;
  logic              addr_load;
  logic [ADDR_W-1:0] addr_init;
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        icode, ifun, rA, rB;
  logic [63:0]       valC;
  logic              wr_en;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;
  logic              done, ins_err, addr_err;
  logic [ADDR_W-1:0] next_pc;

  y86_instr_encoder #(.MEM_BYTES(MEM), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .addr_load(addr_load), .addr_init(addr_init),
    .in_valid(in_valid), .in_ready(in_ready), .icode(icode), .ifun(ifun),
    .rA(rA), .rB(rB), .valC(valC), .wr_en(wr_en), .wr_ready(wr_ready),
    .wr_addr(wr_addr), .wr_data(wr_data), .done(done), .ins_err(ins_err),
    .addr_err(addr_err), .next_pc(next_pc)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] a;
    logic [7:0]  d;
  } wr_t;

  wr_t         sb[$];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          acc_cyc = 0;
  logic [63:0] mpc = '0;
  logic [63:0] mbase = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int model_len(input logic [3:0] c);
    case (c)
      4'h0, 4'h1, 4'h9:       return 1;
      4'h2, 4'h6, 4'hA, 4'hB: return 2;
      4'h7, 4'h8:             return 9;
      4'h3, 4'h4, 4'h5:       return 10;
      default:                return 0;
    endcase
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Write monitor: every accepted byte is compared against the queue; a
  // stalled byte must stay put until it is accepted.
  initial begin
    logic        stall_prev;
    logic [63:0] hold_a;
    logic [7:0]  hold_d;
    wr_t         e;
    stall_prev = 1'b0;
    hold_a = '0;
    hold_d = '0;
    forever begin
      @(negedge clk);
      if (stall_prev) begin
        check("stall_en", {63'h0, wr_en}, 64'h1);
        check("stall_addr", wr_addr, hold_a);
        check("stall_data", {56'h0, wr_data}, {56'h0, hold_d});
      end
      stall_prev = wr_en && !wr_ready;
      hold_a = wr_addr;
      hold_d = wr_data;
      if (wr_en && wr_ready) begin
        if (sb.size() == 0) begin
          check("unexp_wr", {63'h0, wr_en}, 64'h0);
        end else begin
          e = sb.pop_front();
          check("wr_addr", wr_addr, e.a);
          check("wr_data", {56'h0, wr_data}, {56'h0, e.d});
        end
      end
    end
  end

  // Presents one instruction; kind: 0 accepted, 1 invalid icode, 2 overflow.
  task automatic issue(input logic ld, input logic [63:0] init,
                       input logic [3:0] ic, input logic [3:0] f,
                       input logic [3:0] a, input logic [3:0] b,
                       input logic [63:0] c, output int kind, output int len);
    int n;
    int p;
    logic [7:0]  bytes [10];
    logic [64:0] endp;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("in_ready", {63'h0, in_ready}, 64'h1);
    addr_load = ld;
    addr_init = init;
    icode = ic; ifun = f; rA = a; rB = b; valC = c;
    in_valid = 1'b1;
    if (ld) mpc = init;
    len = model_len(ic);
    endp = {1'b0, mpc} + 65'(len);
    if (len == 0) begin
      kind = 1;
    end else if (endp > 65'(MEM)) begin
      kind = 2;
    end else begin
      kind = 0;
      mbase = mpc;
      bytes[0] = {ic, f};
      p = 1;
      if (len == 2 || len == 10) begin
        bytes[p] = {a, b};
        p++;
      end
      if (len >= 9) begin
        for (int i = 0; i < 8; i++) begin
          bytes[p] = c[8*i +: 8];
          p++;
        end
      end
      for (int j = 0; j < len; j++) sb.push_back('{a: mbase + 64'(j), d: bytes[j]});
    end
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    in_valid = 1'b0;
    addr_load = 1'b0;
  endtask

  task automatic finish_instr(input int kind, input int len, input int stalls, input string tag);
    int n;
    if (kind == 0) begin
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!done && n < 60);
      if (!done) begin
        check({tag, "_done_timeout"}, {63'h0, done}, 64'h1);
      end else begin
        check({tag, "_latency"}, 64'(cyc - acc_cyc), 64'(len + stalls));
        check({tag, "_sb_empty"}, 64'(sb.size()), 64'h0);
        mpc = mbase + 64'(len);
        check({tag, "_next_pc"}, next_pc, mpc);
        @(negedge clk);
        check({tag, "_done_pulse"}, {63'h0, done}, 64'h0);
      end
    end else begin
      @(negedge clk);
      check({tag, "_ins_err"}, {63'h0, ins_err}, {63'h0, kind == 1});
      check({tag, "_addr_err"}, {63'h0, addr_err}, {63'h0, kind == 2});
      check({tag, "_wr_en"}, {63'h0, wr_en}, 64'h0);
      check({tag, "_next_pc"}, next_pc, mpc);
      @(negedge clk);
      check({tag, "_err_pulse"}, {62'h0, ins_err, addr_err}, 64'h0);
    end
  endtask

  initial begin
    int k;
    int l;
    reset = 1'b1;
    addr_load = 1'b0; addr_init = '0; in_valid = 1'b0;
    icode = '0; ifun = '0; rA = '0; rB = '0; valC = '0;
    wr_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_in_ready", {63'h0, in_ready}, 64'h1);
    check("rst_flags", {60'h0, wr_en, done, ins_err, addr_err}, 64'h0);
    check("rst_wr_addr", wr_addr, 64'h0);
    check("rst_wr_data", {56'h0, wr_data}, 64'h0);
    check("rst_next_pc", next_pc, 64'h0);

    issue(1'b0, 64'h0, 4'h1, 4'h0, 4'h0, 4'h0, 64'h0, k, l);
    finish_instr(k, l, 0, "nop");

    issue(1'b1, 64'h10, 4'h3, 4'h0, 4'hF, 4'h3, 64'h0123456789ABCDEF, k, l);
    finish_instr(k, l, 0, "irmovq");

    issue(1'b0, 64'h0, 4'h8, 4'h0, 4'h0, 4'h0, 64'h40, k, l);
    repeat (2) @(posedge clk);
    #1 wr_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 wr_ready = 1'b1;
    finish_instr(k, l, 3, "call_stall");

    issue(1'b0, 64'h0, 4'hC, 4'h0, 4'h1, 4'h2, 64'h0, k, l);
    finish_instr(k, l, 0, "bad_icode");

    issue(1'b0, 64'h0, 4'h6, 4'h1, 4'h2, 4'h3, 64'h0, k, l);
    finish_instr(k, l, 0, "opq");

    issue(1'b0, 64'h0, 4'h7, 4'h3, 4'h0, 4'h0, 64'h1122334455667788, k, l);
    finish_instr(k, l, 0, "jxx");

    issue(1'b1, 64'd1020, 4'hD, 4'h0, 4'h0, 4'h0, 64'h0, k, l);
    finish_instr(k, l, 0, "bad_and_ovf");

    issue(1'b0, 64'h0, 4'h4, 4'h0, 4'h1, 4'h2, 64'h8, k, l);
    finish_instr(k, l, 0, "rmmovq_ovf");

    issue(1'b0, 64'h0, 4'h9, 4'h0, 4'h0, 4'h0, 64'h0, k, l);
    finish_instr(k, l, 0, "ret_top");

    issue(1'b1, 64'd1014, 4'h5, 4'h0, 4'h3, 4'h4, 64'hDEADBEEFCAFEF00D, k, l);
    finish_instr(k, l, 0, "mrmovq_fit");

    issue(1'b0, 64'h0, 4'h0, 4'h0, 4'h0, 4'h0, 64'h0, k, l);
    finish_instr(k, l, 0, "halt_full");

    issue(1'b1, 64'h100, 4'h3, 4'h0, 4'hF, 4'h1, 64'hA5A5A5A55A5A5A5A, k, l);
    repeat (4) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    sb.delete();
    mpc = '0;
    @(negedge clk);
    check("midrst_wr_en", {63'h0, wr_en}, 64'h0);
    check("midrst_in_ready", {63'h0, in_ready}, 64'h1);
    check("midrst_next_pc", next_pc, 64'h0);

    issue(1'b0, 64'h0, 4'h1, 4'h0, 4'h0, 4'h0, 64'h0, k, l);
    finish_instr(k, l, 0, "nop_after_rst");

    repeat (2) @(negedge clk);
    check("sb_final", 64'(sb.size()), 64'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
